// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: multi-channel PWM generator with per-channel linear fade.
//
// A shared period counter drives CH PWM outputs. Duty commands arrive over a
// valid/ready handshake, and each one either jumps a channel straight to its
// new duty or lets it fade there one LSB every FADE_DIV periods. The duty that
// is actually compared against the counter (act) is only reloaded on the last
// count of a period, so a period never shows a runt pulse.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   cmd_valid    command present
//   cmd_ready    block can accept a command this cycle
//   cmd_ch       target channel index
//   cmd_duty     target duty (high cycles per period)
//   cmd_fade     0 = jump immediately, 1 = fade toward target
//   cmd_err      one-cycle pulse: command dropped (cmd_ch >= CH)
//   period_tick  one-cycle pulse in the cycle where the counter is 0
//   busy         some channel has not yet reached its target
//   pwm          PWM outputs, bit i = channel i
//
// Command FSM:
//   state   | meaning
//   S_IDLE  | ready for a command; captures it on cmd_valid && cmd_ready
//   S_APPLY | writes the captured command into the channel registers

module rgb_pwm_fader #(
  parameter int CH       = 3,
  parameter int CNT_W    = 8,
  parameter int PERIOD   = 255,
  parameter int FADE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_ch,
  input  logic [CNT_W-1:0] cmd_duty,
  input  logic             cmd_fade,
  output logic             cmd_err,
  output logic             period_tick,
  output logic             busy,
  output logic [CH-1:0]    pwm
);

  localparam int                PDIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [PDIV_W-1:0] PDIV_LAST = PDIV_W'(FADE_DIV - 1);
  localparam logic [3:0]        CH_L      = 4'(CH);

  typedef enum logic {S_IDLE, S_APPLY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PDIV_W-1:0]  pdiv_q, pdiv_d;
  logic               period_tick_q, period_tick_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               cmd_err_q, cmd_err_d;
  logic [2:0]         cap_ch_q, cap_ch_d;
  logic [CNT_W-1:0]   cap_duty_q, cap_duty_d;
  logic               cap_fade_q, cap_fade_d;
  logic [CNT_W-1:0]   tgt_q [CH];
  logic [CNT_W-1:0]   tgt_d [CH];
  logic [CNT_W-1:0]   cur_q [CH];
  logic [CNT_W-1:0]   cur_d [CH];
  logic [CNT_W-1:0]   act_q [CH];
  logic [CNT_W-1:0]   act_d [CH];
  logic [CH-1:0]      pwm_q, pwm_d;

  logic accept;
  logic apply_ok;
  logic fade_step;

  always_comb begin
    cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    period_tick_d = (cnt_d == '0);

    // pdiv is a down-counter of period ticks; the tick that finds it at zero
    // is the one that advances every fading channel.
    fade_step = period_tick_q && (pdiv_q == '0);
    pdiv_d    = pdiv_q;
    if (period_tick_q) begin
      pdiv_d = (pdiv_q == '0) ? PDIV_LAST : pdiv_q - PDIV_W'(1);
    end

    accept     = cmd_valid && cmd_ready_q;
    state_d    = state_q;
    cap_ch_d   = cap_ch_q;
    cap_duty_d = cap_duty_q;
    cap_fade_d = cap_fade_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_APPLY;
          cap_ch_d   = cmd_ch;
          cap_duty_d = cmd_duty;
          cap_fade_d = cmd_fade;
        end
      end
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    // Flagged at capture time so the registered pulse lines up with APPLY.
    cmd_err_d   = accept && ({1'b0, cmd_ch} >= CH_L);
    apply_ok    = (state_q == S_APPLY) && ({1'b0, cap_ch_q} < CH_L);

    for (int k = 0; k < CH; k++) begin
      tgt_d[k] = tgt_q[k];
      cur_d[k] = cur_q[k];
      // A command landing on a channel's step cycle replaces that step.
      if (apply_ok && (cap_ch_q == 3'(k))) begin
        tgt_d[k] = cap_duty_q;
        if (!cap_fade_q) begin
          cur_d[k] = cap_duty_q;
        end
      end else if (fade_step && (cur_q[k] != tgt_q[k])) begin
        cur_d[k] = (cur_q[k] < tgt_q[k]) ? cur_q[k] + CNT_W'(1) : cur_q[k] - CNT_W'(1);
      end
      act_d[k] = (cnt_q == CNT_LAST) ? cur_q[k] : act_q[k];
      pwm_d[k] = (cnt_d < act_d[k]);
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < CH; k++) begin
      busy = busy | (cur_q[k] != tgt_q[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pdiv_q        <= PDIV_LAST;
      period_tick_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      cmd_err_q     <= 1'b0;
      cap_ch_q      <= '0;
      cap_duty_q    <= '0;
      cap_fade_q    <= 1'b0;
      pwm_q         <= '0;
      for (int k = 0; k < CH; k++) begin
        tgt_q[k] <= '0;
        cur_q[k] <= '0;
        act_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pdiv_q        <= pdiv_d;
      period_tick_q <= period_tick_d;
      cmd_ready_q   <= cmd_ready_d;
      cmd_err_q     <= cmd_err_d;
      cap_ch_q      <= cap_ch_d;
      cap_duty_q    <= cap_duty_d;
      cap_fade_q    <= cap_fade_d;
      pwm_q         <= pwm_d;
      for (int k = 0; k < CH; k++) begin
        tgt_q[k] <= tgt_d[k];
        cur_q[k] <= cur_d[k];
        act_q[k] <= act_d[k];
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign cmd_err     = cmd_err_q;
  assign period_tick = period_tick_q;
  assign pwm         = pwm_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Self-checking bench for rgb_pwm_fader (CH=3, CNT_W=8, PERIOD=16, FADE_DIV=2).
// A time-indexed reference model predicts every output on every cycle; a
// command table and hand-written sequences add direct high-time checks.

module tb_rgb_pwm_fader;

  localparam int CH       = 3;
  localparam int CNT_W    = 8;
  localparam int PERIOD   = 16;
  localparam int FADE_DIV = 2;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_ch;
  logic [CNT_W-1:0] cmd_duty;
  logic             cmd_fade;
  logic             cmd_err;
  logic             period_tick;
  logic             busy;
  logic [CH-1:0]    pwm;

  rgb_pwm_fader #(
    .CH(CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .FADE_DIV(FADE_DIV)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_duty(cmd_duty), .cmd_fade(cmd_fade),
    .cmd_err(cmd_err), .period_tick(period_tick), .busy(busy), .pwm(pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time t counts cycles since reset release.
  int m_t;
  int m_cur [CH];
  int m_tgt [CH];
  int m_act [CH];
  bit m_pend;
  int m_pch;
  int m_pduty;
  bit m_pfade;
  bit m_ready;
  bit m_err;

  typedef struct {
    int ch;
    int duty;
    bit fade;
    int exp_hi;
    bit exp_err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0d expected %0d", name, m_t, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout at t=%0d", name, m_t);
  endtask

  function automatic bit m_busy();
    bit b = 1'b0;
    for (int k = 0; k < CH; k++) if (m_cur[k] != m_tgt[k]) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    m_t = 0;
    for (int k = 0; k < CH; k++) begin
      m_cur[k] = 0; m_tgt[k] = 0; m_act[k] = 0;
    end
    m_pend = 0; m_pch = 0; m_pduty = 0; m_pfade = 0;
    m_ready = 0; m_err = 0;
  endtask

  task automatic check_now();
    int cnt;
    int exp_pwm;
    cnt = m_t % PERIOD;
    exp_pwm = 0;
    for (int k = 0; k < CH; k++) if (cnt < m_act[k]) exp_pwm |= (1 << k);
    chk("pwm", int'(pwm), exp_pwm);
    chk("busy", int'(busy), int'(m_busy()));
    chk("cmd_ready", int'(cmd_ready), int'(m_ready));
    chk("cmd_err", int'(cmd_err), int'(m_err));
    chk("period_tick", int'(period_tick), int'(m_t > 0 && cnt == 0));
  endtask

  // Advance the model across the coming clock edge using the driven inputs.
  task automatic model_edge();
    int  old_cur [CH];
    int  applied;
    bit  step;
    bit  acc;
    old_cur = m_cur;
    applied = -1;
    // Fade steps happen on every FADE_DIV-th period boundary.
    step = (m_t > 0) && (m_t % PERIOD == 0) && ((m_t / PERIOD) % FADE_DIV == 0);
    if (m_t % PERIOD == PERIOD - 1) m_act = old_cur;
    if (m_pend && m_pch < CH) begin
      applied = m_pch;
      m_tgt[m_pch] = m_pduty;
      if (!m_pfade) m_cur[m_pch] = m_pduty;
    end
    if (step) begin
      for (int k = 0; k < CH; k++) begin
        if (k != applied) begin
          if (old_cur[k] < m_tgt[k]) m_cur[k] = old_cur[k] + 1;
          else if (old_cur[k] > m_tgt[k]) m_cur[k] = old_cur[k] - 1;
        end
      end
    end
    acc = cmd_valid && m_ready;
    m_pend = acc;
    if (acc) begin
      m_pch = int'(cmd_ch); m_pduty = int'(cmd_duty); m_pfade = cmd_fade;
    end
    m_err = acc && (int'(cmd_ch) >= CH);
    m_ready = !acc;
    m_t++;
  endtask

  task automatic cycle();
    check_now();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int ch, input int duty, input bit fade, output int err_seen);
    int n;
    cmd_ch = 3'(ch); cmd_duty = CNT_W'(duty); cmd_fade = fade;
    cmd_valid = 1'b1;
    n = 0;
    while (!m_ready && n < 50) begin cycle(); n++; end
    if (n >= 50) timeout_fail("send_ready");
    cycle();
    cmd_valid = 1'b0;
    err_seen = int'(cmd_err);
    cycle();
  endtask

  task automatic wait_settle();
    int n = 0;
    while (m_busy() && n < 20000) begin cycle(); n++; end
    if (n >= 20000) timeout_fail("settle");
    repeat (2 * PERIOD) cycle();
  endtask

  task automatic measure(input int ch, output int hi);
    int n = 0;
    while ((m_t % PERIOD) != 0 && n < PERIOD + 2) begin cycle(); n++; end
    if (n >= PERIOD + 2) timeout_fail("measure_align");
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      hi += int'(pwm[ch]);
      cycle();
    end
  endtask

  task automatic wait_until_cnt(input int c);
    int n = 0;
    while ((m_t % PERIOD) != c && n < PERIOD + 2) begin cycle(); n++; end
    if (n >= PERIOD + 2) timeout_fail("wait_cnt");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int hi;
    int lv [16];
    int seq [5];
    int idx;
    int n;
    int minv;
    int dwell;
    bit r;

    tbl = '{
      '{1, 5,   1'b0, 5,  1'b0},
      '{0, 16,  1'b0, 16, 1'b0},
      '{0, 200, 1'b0, 16, 1'b0},
      '{0, 0,   1'b0, 0,  1'b0},
      '{3, 9,   1'b0, 0,  1'b1},
      '{2, 15,  1'b0, 15, 1'b0},
      '{1, 3,   1'b1, 3,  1'b0},
      '{7, 1,   1'b0, 0,  1'b1},
      '{2, 1,   1'b1, 1,  1'b0},
      '{0, 255, 1'b0, 16, 1'b0}
    };

    rst = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_duty = '0; cmd_fade = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(period_tick), 0);
    rst = 1'b0;
    model_reset();
    repeat (3 * PERIOD) cycle();

    // Immediate set landing mid-period.
    wait_until_cnt(7);
    send(1, 5, 1'b0, e);
    measure(1, hi);
    chk("mid_set_hi", hi, 5);
    measure(0, hi);
    chk("mid_set_ch0", hi, 0);

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].ch, tbl[i].duty, tbl[i].fade, e);
      chk("tbl_err", e, int'(tbl[i].exp_err));
      wait_settle();
      if (!tbl[i].exp_err) begin
        measure(tbl[i].ch, hi);
        chk("tbl_hi", hi, tbl[i].exp_hi);
      end
    end

    // Fade 0 -> 4 and back down to 1.
    send(2, 0, 1'b0, e);
    wait_settle();
    send(2, 4, 1'b1, e);
    chk("fade_busy", int'(busy), 1);
    for (int p = 0; p < 14; p++) measure(2, lv[p]);
    for (int p = 1; p < 14; p++) chk("fade_up_delta", int'((lv[p] - lv[p-1]) inside {0, 1}), 1);
    for (int l = 1; l < 4; l++) begin
      dwell = 0;
      for (int p = 0; p < 14; p++) if (lv[p] == l) dwell++;
      chk("fade_up_dwell", dwell, FADE_DIV);
    end
    chk("fade_up_final", lv[13], 4);
    chk("fade_up_idle", int'(busy), 0);
    send(2, 1, 1'b1, e);
    minv = 99;
    for (int p = 0; p < 12; p++) begin
      measure(2, lv[p]);
      if (lv[p] < minv) minv = lv[p];
    end
    for (int p = 1; p < 12; p++) chk("fade_dn_delta", int'((lv[p] - lv[p-1]) inside {0, -1}), 1);
    chk("fade_dn_final", lv[11], 1);
    chk("fade_dn_min", minv, 1);

    // Back-to-back commands with valid held high.
    wait_settle();
    cmd_valid = 1'b1; cmd_ch = 3'd0; cmd_duty = 8'd3; cmd_fade = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      seq[c] = int'(cmd_ready);
      r = m_ready;
      cycle();
      if (r) begin
        idx++;
        if (idx == 1) begin cmd_ch = 3'd1; cmd_duty = 8'd8; end
        if (idx == 2) begin cmd_ch = 3'd2; cmd_duty = 8'd12; end
        if (idx == 3) cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) chk("b2b_ready", seq[c], (c % 2 == 0) ? 1 : 0);
    wait_settle();
    measure(1, hi);
    chk("b2b_ch1", hi, 8);

    // Immediate command whose APPLY lands on a fade-step cycle.
    send(2, 0, 1'b1, e);
    send(0, 10, 1'b1, e);
    n = 0;
    while (!((m_t % (PERIOD * FADE_DIV)) == PERIOD * FADE_DIV - 1 && m_ready) && n < 200) begin
      cycle(); n++;
    end
    if (n >= 200) timeout_fail("collide_align");
    cmd_ch = 3'd2; cmd_duty = 8'd7; cmd_fade = 1'b0; cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    measure(2, hi);
    measure(2, hi);
    chk("collide_hi", hi, 7);

    // Reset in the middle of a fade.
    send(1, 200, 1'b0, e);
    wait_settle();
    send(1, 0, 1'b1, e);
    repeat (3 * PERIOD) cycle();
    wait_until_cnt(9);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_pwm", int'(pwm), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(cmd_ready), 0);
    chk("arst_tick", int'(period_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2 * PERIOD) cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      int ch, duty, gap;
      bit fade;
      gap  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 4);
      repeat (gap) cycle();
      ch   = $urandom_range(0, 3);
      fade = 1'($urandom_range(0, 1));
      duty = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 20);
      send(ch, duty, fade, e);
      chk("rnd_err", e, int'(ch >= CH));
    end
    wait_settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
Parametrised multi-channel PWM generator, the successor to the single-colour 15-step LED PWM. It accepts per-channel duty commands from the UART command decoder over a valid/ready handshake. Each channel either jumps to its new duty immediately or fades linearly toward it. Duty changes take effect only at PWM period boundaries, so no output ever shows a glitched (runt) pulse. It drives the RGB LED pins directly.

Parameters:
CH, 3, number of PWM channels (1..8)
CNT_W, 8, width of period counter and duty values
PERIOD, 255, counter counts 0..PERIOD-1 (2..2^CNT_W)
FADE_DIV, 4, number of PWM periods per 1-LSB fade step (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command this cycle
cmd_ch  in  3  target channel index
cmd_duty  in  CNT_W  target duty (high cycles per period)
cmd_fade  in  1  0 = immediate, 1 = fade toward target
cmd_err  out  1  one-cycle pulse: command dropped (cmd_ch >= CH)
period_tick  out  1  one-cycle pulse when counter wraps to 0
busy  out  1  OR over channels of (cur_duty != tgt_duty)
pwm  out  CH  PWM outputs, bit i = channel i

Behaviour:
- Reset (async, rst=1): cnt=0; all tgt_duty, cur_duty and act_duty=0; pwm=0; cmd_ready=0; cmd_err=0; period_tick=0; busy=0; FSM=IDLE. First edge after release: cmd_ready rises.
- Counter: cnt increments every clk. At cnt==PERIOD-1 it wraps to 0. period_tick is registered and is high in the cycle where cnt==0.
- Command FSM, states IDLE and APPLY:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, capture the fields and go to APPLY.
  - APPLY: cmd_ready=0. Validate and apply the captured command, then return to IDLE. Throughput is one command per 2 cycles.
- Apply rules for a valid channel k:
  - tgt_duty[k]=cmd_duty in all cases.
  - If cmd_fade=0, also cur_duty[k]=cmd_duty.
  - If cmd_fade=1, cur_duty[k] is unchanged and ramps toward the target.
- Invalid channel (cmd_ch>=CH): no state change; cmd_err=1 for the APPLY cycle only.
- Fade engine:
  - A period counter pdiv counts period_tick pulses, 0..FADE_DIV-1.
  - On the tick where pdiv wraps, every channel with cur!=tgt steps cur by exactly 1 toward tgt.
  - No overshoot; no wrap at 0 or 2^CNT_W-1.
- Simultaneous events: an APPLY and a fade step on the same channel in the same cycle → APPLY wins and the fade step for that channel is discarded. Other channels still step.
- Shadowing: act_duty[k] <= cur_duty[k] only in the cycle where cnt==PERIOD-1, so it takes effect from cnt==0. Mid-period changes to cur_duty never alter the current period.
- Output: pwm[k] is registered, pwm[k] <= (cnt_next < act_duty_next[k]). pwm is therefore aligned to cnt: high for cnt in 0..act_duty-1.
  - act_duty=0 → constant 0.
  - act_duty>=PERIOD → constant 1 (no gap at wrap).
- Latency: command accepted at cycle N → cur updated at N+1 → visible on pwm at the next cnt==0.
- busy is combinational from registers and is low when all channels have settled.
- Reset mid-fade or mid-APPLY: all state is cleared immediately and the pending command is lost. The FSM resumes in IDLE.

Test Plan:
(All scenarios use CH=3, CNT_W=8, PERIOD=16, FADE_DIV=2 unless stated.)
1. Reset, then idle. Response: pwm=000, cmd_ready=1 one cycle after release, period_tick every 16 cycles at cnt=0.
2. Immediate set ch1 duty=5 mid-period (cnt=7). Response: pwm[1] stays 0 until the next cnt=0, then high exactly 5 of every 16 cycles; pwm[0], pwm[2] stay 0.
3. Duty extremes on ch0: duty=16 → pwm[0] constant 1 across wraps; duty=200 → constant 1; duty=0 → constant 0 from the next period.
4. Fade ch2 0→4 with cmd_fade=1. Response: busy=1; high-time per period runs 0,0,1,1,2,2,3,3,4, then steady; busy drops when cur=4. Fade down 4→1 decrements symmetrically with no overshoot.
5. Handshake and errors:
   - cmd_valid held high for 3 back-to-back commands: each accepted on alternate cycles (cmd_ready 1,0,1,0,1).
   - cmd_ch=3: cmd_err pulses 1 cycle, no pwm change.
6. Collision and reset:
   - Immediate command to a fading channel on its fade-step cycle: new value wins.
   - Assert rst mid-fade with cnt=9: pwm=000 and cnt=0 immediately (asynchronous), busy=0.
